// File: rtl/lc4_encoder.sv
// lc4_encoder: packs decoded LC4 instruction fields into 20-bit words,
// buffers them in a small FIFO and streams them into IMEM at consecutive
// addresses starting from a programmable base.
// Optional build macro: LC4_ENC_RANGE_CHECK_EN (reject immediates that do
// not fit the signed field; otherwise immediates are truncated).
module lc4_encoder #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [19:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   words_written,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              range_err
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [PTR_W:0]    PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } enc_req_t;

    enc_req_t          req;
    logic [1:0]        state;
    logic [19:0]       fifo_mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              fifo_empty;
    logic              fifo_full;
    logic              op_legal;
    logic              imm_ok;
    logic [19:0]       packed_word;
    logic              accept;
    logic              push;
    logic              pop;

    assign req = '{op: in_opcode, rd: in_rd, rs: in_rs, rt: in_rt, imm: in_imm};

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign busy          = (state != S_IDLE);
    assign in_ready      = (state == S_RUN) && !fifo_full;
    assign mem_we        = busy && !fifo_empty;
    assign mem_addr      = addr_q;
    // Zero the data bus while idle so unwritten FIFO storage never leaks out.
    assign mem_wdata     = mem_we ? fifo_mem[rd_ptr[PTR_W-1:0]] : 20'd0;
    assign words_written = cnt_q;

    // A start in the same cycle wins: the FIFO is flushed, so any concurrent
    // transfer or write is discarded.
    assign accept = in_valid && in_ready;
    assign push   = accept && op_legal && imm_ok && !start;
    assign pop    = mem_we && mem_ready && !start;

    // Opcode decode and field packing; unused fields are ignored.
    always_comb begin
        op_legal    = 1'b1;
        packed_word = {req.op, 15'd0};
        case (req.op)
            5'b00101, 5'b00110, 5'b01100, 5'b01101,
            5'b01110, 5'b01111, 5'b10001:
                packed_word = {req.op, req.rd, req.rs, req.rt};
            5'b00111, 5'b01001:
                packed_word = {req.op, req.rd, req.rs, req.imm[4:0]};
            5'b01011:
                packed_word = {req.op, req.rd, req.imm[9:0]};
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000:
                packed_word = {req.op, req.imm[14:0]};
            5'b00000, 5'b01010:
                packed_word = {req.op, 15'd0};
            default:
                op_legal = 1'b0;
        endcase
    end

`ifdef LC4_ENC_RANGE_CHECK_EN
    // Immediate fits when every bit above the field matches the field's sign bit.
    always_comb begin
        imm_ok = 1'b1;
        case (req.op)
            5'b00111, 5'b01001:
                imm_ok = (req.imm[15:4] == {12{req.imm[4]}});
            5'b01011:
                imm_ok = (req.imm[15:9] == {7{req.imm[9]}});
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000:
                imm_ok = (req.imm[15] == req.imm[14]);
            default:
                imm_ok = 1'b1;
        endcase
    end

    // Out-of-range pulse for a legal opcode whose immediate was rejected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) range_err <= 1'b0;
        else     range_err <= accept && op_legal && !imm_ok && !start;
    end
`else
    logic unused_imm_msb;
    assign unused_imm_msb = req.imm[15];
    assign imm_ok         = 1'b1;
    assign range_err      = 1'b0;
`endif

    // FIFO storage: written on push only, never reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= packed_word;
    end

    // Control FSM, FIFO pointers, IMEM address and write counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= accept && !op_legal && !start;
            if (start) begin
                state  <= S_RUN;
                wr_ptr <= '0;
                rd_ptr <= '0;
                addr_q <= base_addr;
                cnt_q  <= '0;
            end else begin
                case (state)
                    S_RUN:   if (finish) state <= S_DRAIN;
                    S_DRAIN: if (fifo_empty) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= state;
                endcase
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    addr_q <= addr_q + ADDR_ONE;
                    if (~&cnt_q) cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lc4_encoder.sv
// tb_lc4_encoder: scoreboard bench for lc4_encoder (ADDR_W=16, DEPTH=4).
// Expected words are pushed when a request is accepted and popped by a
// write monitor when the DUT performs an IMEM write.
module tb_lc4_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic        finish;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode, in_rd, in_rs, in_rt;
    logic [15:0] in_imm;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [19:0] mem_wdata;
    logic        mem_ready;
    logic [16:0] words_written;
    logic        busy, done, illegal, range_err;

    typedef struct {
        logic [15:0] addr;
        logic [19:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] nxt_addr;
    int          n_cmp  = 0;
    int          n_fail = 0;

    lc4_encoder #(.ADDR_W(16), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .words_written(words_written), .busy(busy), .done(done),
        .illegal(illegal), .range_err(range_err)
    );

    always #5 clk = ~clk;

    // 0 = enqueued, 1 = illegal opcode, 2 = immediate out of range
    function automatic int model_kind(input logic [4:0] op, input logic [15:0] imm);
        int v;
        v = $signed(imm);
        if (!(op <= 5'd15 || op == 5'd17)) return 1;
`ifdef LC4_ENC_RANGE_CHECK_EN
        if ((op == 5'd7 || op == 5'd9) && (v < -16 || v > 15)) return 2;
        if (op == 5'd11 && (v < -512 || v > 511)) return 2;
        if (((op >= 5'd1 && op <= 5'd4) || op == 5'd8) && (v < -16384 || v > 16383)) return 2;
`else
        if (v == 0) return 0;
`endif
        return 0;
    endfunction

    function automatic logic [19:0] model_word(input logic [4:0] op, rd, rs, rt,
                                               input logic [15:0] imm);
        case (op)
            5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd15, 5'd17: return {op, rd, rs, rt};
            5'd7, 5'd9:                     return {op, rd, rs, imm[4:0]};
            5'd11:                          return {op, rd, imm[9:0]};
            5'd1, 5'd2, 5'd3, 5'd4, 5'd8:   return {op, imm[14:0]};
            default:                        return {op, 15'd0};
        endcase
    endfunction

    // Write monitor: every IMEM write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected addr=%h data=%h expected none", mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL write_data got addr=%h data=%h expected addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
        sb.delete();
        nxt_addr  = base;
    endtask

    // Offer one request; record the expected word once it is accepted.
    task automatic send(input logic [4:0] op, rd, rs, rt, input logic [15:0] imm);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_imm    = imm;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                if (model_kind(op, imm) == 0) begin
                    sb.push_back('{addr: nxt_addr, data: model_word(op, rd, rs, rt, imm)});
                    nxt_addr = nxt_addr + 16'd1;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout got in_ready=0 expected accept of op=%b", op);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; finish = 0; in_valid = 0; mem_ready = 0;
        base_addr = 0; in_opcode = 0; in_rd = 0; in_rs = 0; in_rt = 0; in_imm = 0;
        nxt_addr = 0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, mem_we, busy, done, illegal, range_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b expected 000000",
                     {in_ready, mem_we, busy, done, illegal, range_err});
        end
        n_cmp++;
        if (words_written !== 17'd0 || mem_addr !== 16'd0 || mem_wdata !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_values got ww=%h addr=%h data=%h expected 0",
                     words_written, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_basic();
        mem_ready = 1'b1;
        do_start(16'h0010);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_entry got busy=%b we=%b rdy=%b expected 1 0 1", busy, mem_we, in_ready);
        end
        tick();
        send(5'b00101, 5'd3, 5'd1, 5'd2, 16'h0);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 20'h28C22) begin
            n_fail++;
            $display("FAIL add_latency got we=%b addr=%h data=%h expected 1 0010 28c22",
                     mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (words_written !== 17'd1) begin
            n_fail++;
            $display("FAIL add_count got %0d expected 1", words_written);
        end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b0;
        do_start(16'h0010);
        send(5'b01011, 5'd4, 5'd0, 5'd0, 16'hFFFF);
        send(5'b00111, 5'd2, 5'd2, 5'd0, 16'hFFFD);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 20'h593FF) begin
            n_fail++;
            $display("FAIL b2b_first got we=%b addr=%h data=%h expected 1 0010 593ff",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0011 || mem_wdata !== 20'h3885D) begin
            n_fail++;
            $display("FAIL b2b_second got we=%b addr=%h data=%h expected 1 0011 3885d",
                     mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (words_written !== 17'd2 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count got ww=%0d we=%b expected 2 0", words_written, mem_we);
        end
    endtask

    task automatic test_illegal();
        logic [16:0] ww0;
        mem_ready = 1'b1;
        ww0 = words_written;
        send(5'b10010, 5'd1, 5'd1, 5'd1, 16'h0);
        @(negedge clk);
        n_cmp++;
        if (illegal !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse got ill=%b we=%b expected 1 0", illegal, mem_we);
        end
        @(negedge clk);
        n_cmp++;
        if (illegal !== 1'b0 || words_written !== ww0) begin
            n_fail++;
            $display("FAIL illegal_after got ill=%b ww=%0d expected 0 %0d", illegal, words_written, ww0);
        end
    endtask

    task automatic test_full();
        mem_ready = 1'b0;
        do_start(16'h0100);
        for (int i = 0; i < 4; i++) send(5'b00110, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0);
        in_valid = 1'b1;
        in_opcode = 5'b01100;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL full_stall got rdy=%b we=%b expected 0 1", in_ready, mem_we);
        end
        tick();
        mem_ready = 1'b1;
        send(5'b01100, 5'd7, 5'd6, 5'd5, 16'h0);
        send(5'b10001, 5'd31, 5'd30, 5'd29, 16'h0);
        wait_drain();
        n_cmp++;
        if (words_written !== 17'd6) begin
            n_fail++;
            $display("FAIL full_count got %0d expected 6", words_written);
        end
    endtask

    task automatic test_wrap();
        bit seen;
        seen = 1'b0;
        mem_ready = 1'b1;
        do_start(16'hFFFE);
        send(5'b01000, 5'd9, 5'd9, 5'd9, 16'hC000);
        send(5'b01010, 5'd3, 5'd3, 5'd3, 16'h1234);
        send(5'b00011, 5'd0, 5'd0, 5'd0, 16'h3FFF);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || busy !== 1'b0 || mem_addr !== 16'h0001 || words_written !== 17'd3) begin
            n_fail++;
            $display("FAIL wrap_done got done_seen=%b busy=%b addr=%h ww=%0d expected 1 0 0001 3",
                     seen, busy, mem_addr, words_written);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single got done=%b rdy=%b expected 0 0", done, in_ready);
        end
    endtask

    task automatic test_range();
        mem_ready = 1'b1;
        do_start(16'h0020);
        send(5'b00111, 5'd1, 5'd0, 5'd0, 16'd16);
        @(negedge clk);
        n_cmp++;
`ifdef LC4_ENC_RANGE_CHECK_EN
        if (range_err !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL range_reject got rerr=%b we=%b expected 1 0", range_err, mem_we);
        end
`else
        if (range_err !== 1'b0 || mem_we !== 1'b1 || mem_wdata[4:0] !== 5'b10000) begin
            n_fail++;
            $display("FAIL range_trunc got rerr=%b we=%b imm=%b expected 0 1 10000",
                     range_err, mem_we, mem_wdata[4:0]);
        end
`endif
        tick();
        send(5'b00111, 5'd2, 5'd3, 5'd0, 16'hFFF0);
        send(5'b01011, 5'd5, 5'd0, 5'd0, 16'd511);
        send(5'b00001, 5'd0, 5'd0, 5'd0, 16'd16384);
        wait_drain();
        n_cmp++;
`ifdef LC4_ENC_RANGE_CHECK_EN
        if (words_written !== 17'd2) begin
            n_fail++;
            $display("FAIL range_count got %0d expected 2", words_written);
        end
`else
        if (words_written !== 17'd4) begin
            n_fail++;
            $display("FAIL range_count got %0d expected 4", words_written);
        end
`endif
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        do_start(16'h0040);
        send(5'b00101, 5'd1, 5'd1, 5'd1, 16'h0);
        send(5'b00101, 5'd2, 5'd2, 5'd2, 16'h0);
        do_start(16'h0080);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b0 || words_written !== 17'd0 || mem_addr !== 16'h0080 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush got we=%b ww=%0d addr=%h rdy=%b expected 0 0 0080 1",
                     mem_we, words_written, mem_addr, in_ready);
        end
        tick();
        mem_ready = 1'b1;
        send(5'b01101, 5'd4, 5'd5, 5'd6, 16'h0);
        wait_drain();
        n_cmp++;
        if (words_written !== 17'd1) begin
            n_fail++;
            $display("FAIL flush_count got %0d expected 1", words_written);
        end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        do_start(16'h0055);
        send(5'b00101, 5'd1, 5'd2, 5'd3, 16'h0);
        send(5'b00110, 5'd1, 5'd2, 5'd3, 16'h0);
        rst = 1'b1;
        #2;
        n_cmp++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || words_written !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%b we=%b addr=%h ww=%0d expected 0 0 0000 0",
                     busy, mem_we, mem_addr, words_written);
        end
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle got rdy=%b busy=%b expected 0 0", in_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_full();
        test_wrap();
        test_range();
        test_flush();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
